// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: default widths,
// payload field indices and the all-zero bubble word.
package pipe_pkg;

   localparam int unsigned FIELD_W_DEF   = 32;
   localparam int unsigned NFIELD_DEF    = 5;
   localparam int unsigned TAG_W_DEF     = 4;
   localparam int unsigned CNT_W_DEF     = 16;
   localparam int unsigned PAYLOAD_W_DEF = NFIELD_DEF * FIELD_W_DEF + TAG_W_DEF;

   // Field positions inside the payload; field 0 sits in the LSBs, tag in the MSBs.
   localparam int unsigned F_IR  = 0;
   localparam int unsigned F_PC  = 1;
   localparam int unsigned F_EXT = 2;
   localparam int unsigned F_V1  = 3;
   localparam int unsigned F_V2  = 4;

   // An empty stage presents all zeros, which decodes as IR=0 (NOP).
   localparam logic [PAYLOAD_W_DEF-1:0] BUBBLE = '0;

   // Where the main entry takes its next value from.
   typedef enum logic [1:0] {
      SRC_HOLD = 2'd0,   // keep current contents (stalled)
      SRC_SKID = 2'd1,   // drain the skid entry into main
      SRC_IN   = 2'd2,   // take the upstream payload
      SRC_NONE = 2'd3    // nothing to load: become a bubble
   } main_src_e;

endpackage

// File: rtl/pipe_entry.sv
// One valid+payload register. Clear wins over load and returns the entry
// to the bubble value so an empty slot never carries stale data.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int unsigned W = PAYLOAD_W_DEF
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         i_load,
   input  logic         i_clear,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Entry state: async reset to bubble, clear has priority over load.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_valid <= 1'b0;
         r_data  <= W'(BUBBLE);
      end else if (i_clear) begin
         r_valid <= 1'b0;
         r_data  <= W'(BUBBLE);
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshakes on both sides.
// Handshake: a port transfers on a rising edge only when its valid and
// ready are both 1; valid never depends on ready of the same port.
// SKID=1 gives a two-entry skid stage with a registered in_ready;
// SKID=0 gives a single register with combinational pass-through ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned FIELD_W = FIELD_W_DEF,
   parameter int unsigned NFIELD  = NFIELD_DEF,
   parameter int unsigned TAG_W   = TAG_W_DEF,
   parameter int unsigned SKID    = 1,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic                              Clk,
   input  logic                              Rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [NFIELD*FIELD_W+TAG_W-1:0]   in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [NFIELD*FIELD_W+TAG_W-1:0]   out_data,
   input  logic                              flush,
   output logic [CNT_W-1:0]                  bubble_cnt
);

   localparam int unsigned PW = NFIELD * FIELD_W + TAG_W;

   logic          w_in_xfer;
   logic          w_out_xfer;
   logic          w_main_valid;
   logic [PW-1:0] w_main_data;
   logic          w_main_load;
   logic          w_main_clear;
   logic [PW-1:0] w_main_din;
   logic [CNT_W-1:0] r_bubble_cnt;

   assign w_in_xfer  = in_valid & in_ready;
   assign w_out_xfer = w_main_valid & out_ready;

   pipe_entry #(.W(PW)) u_main (
      .Clk     (Clk),
      .Rst     (Rst),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_data  (w_main_din),
      .o_valid (w_main_valid),
      .o_data  (w_main_data)
   );

   if (SKID != 0) begin : g_skid
      logic          w_skid_valid;
      logic [PW-1:0] w_skid_data;
      logic          w_skid_load;
      logic          w_skid_clear;
      logic          w_skid_valid_nxt;
      logic          r_in_ready;
      main_src_e     w_src;

      pipe_entry #(.W(PW)) u_skid (
         .Clk     (Clk),
         .Rst     (Rst),
         .i_load  (w_skid_load),
         .i_clear (w_skid_clear),
         .i_data  (in_data),
         .o_valid (w_skid_valid),
         .o_data  (w_skid_data)
      );

      // Pick the main entry's source: skid first to keep order, then upstream.
      always_comb begin
         w_src = SRC_HOLD;
         if (!w_main_valid || w_out_xfer) begin
            if (w_skid_valid)   w_src = SRC_SKID;
            else if (w_in_xfer) w_src = SRC_IN;
            else                w_src = SRC_NONE;
         end
      end

      // Skid captures an accepted input only while main is stalled and full.
      assign w_skid_load  = (w_src == SRC_HOLD) && w_in_xfer;
      assign w_skid_clear = flush || (w_src == SRC_SKID);

      assign w_main_load  = (w_src == SRC_SKID) || (w_src == SRC_IN);
      assign w_main_clear = flush || (w_src == SRC_NONE);
      assign w_main_din   = (w_src == SRC_SKID) ? w_skid_data : in_data;

      // Predict skid occupancy after this edge, mirroring the entry priority.
      always_comb begin
         w_skid_valid_nxt = w_skid_valid;
         if (w_skid_clear)     w_skid_valid_nxt = 1'b0;
         else if (w_skid_load) w_skid_valid_nxt = 1'b1;
      end

      // Registered ready: open exactly when the skid entry will be empty.
      always_ff @(posedge Clk or negedge Rst) begin
         if (!Rst) r_in_ready <= 1'b0;
         else      r_in_ready <= ~w_skid_valid_nxt;
      end

      assign in_ready = r_in_ready;
   end else begin : g_pass
      // Ready passes straight through; held low while reset is asserted.
      assign in_ready     = Rst & (out_ready | ~w_main_valid);
      assign w_main_load  = w_in_xfer;
      assign w_main_clear = flush | (w_out_xfer & ~w_in_xfer);
      assign w_main_din   = in_data;
   end

   // Count edges with no valid output, saturating at all-ones.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_bubble_cnt <= '0;
      end else if (!w_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
         r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end

   assign out_valid  = w_main_valid;
   assign out_data   = w_main_data;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default-width skid instance (A) and a small
// pass-through instance with a 4-bit bubble counter (B).
module tb_pipe_stage_reg;

   localparam int DW_A  = 5 * 32 + 4;
   localparam int DW_B  = 2 * 8 + 4;
   localparam int CNT_B = 4;

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
   logic [DW_A-1:0] a_in_data, a_out_data;
   logic [15:0]     a_bubble_cnt;

   logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
   logic [DW_B-1:0]  b_in_data, b_out_data;
   logic [CNT_B-1:0] b_bubble_cnt;

   pipe_stage_reg dut_a (
      .Clk        (Clk),
      .Rst        (Rst),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .in_data    (a_in_data),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
      .out_data   (a_out_data),
      .flush      (a_flush),
      .bubble_cnt (a_bubble_cnt)
   );

   pipe_stage_reg #(
      .FIELD_W (8),
      .NFIELD  (2),
      .TAG_W   (4),
      .SKID    (0),
      .CNT_W   (CNT_B)
   ) dut_b (
      .Clk        (Clk),
      .Rst        (Rst),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .in_data    (b_in_data),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .out_data   (b_out_data),
      .flush      (b_flush),
      .bubble_cnt (b_bubble_cnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [DW_A-1:0] act, input logic [DW_A-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic            iv;
      logic [DW_A-1:0] d;
      logic            ord;
      logic            fl;
      logic            e_ir;
      logic            e_ov;
      logic [DW_A-1:0] e_od;
      logic [15:0]     e_cnt;
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input logic iv, input logic [DW_A-1:0] d, input logic ord, input logic fl,
                          input logic e_ir, input logic e_ov, input logic [DW_A-1:0] e_od,
                          input logic [15:0] e_cnt);
      vec_t v;
      v.iv = iv; v.d = d; v.ord = ord; v.fl = fl;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
      vq.push_back(v);
   endtask

   task automatic drive_a(input vec_t v);
      a_in_valid  = v.iv;
      a_in_data   = v.d;
      a_out_ready = v.ord;
      a_flush     = v.fl;
   endtask

   task automatic idle_b();
      b_in_valid  = 1'b0;
      b_in_data   = '0;
      b_out_ready = 1'b1;
      b_flush     = 1'b0;
   endtask

   function automatic logic [DW_A-1:0] rand_a();
      return {4'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Watchdog: the bench never waits on a DUT event unbounded, but guard anyway.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW_A-1:0] qa[$];
      logic [DW_B-1:0] qb[$];
      logic [DW_A-1:0] ea;
      logic [DW_B-1:0] eb;
      int n_out, k, ir_drops;
      logic a_ix, a_ox, b_ix, b_ox;

      // Sequence after reset release; expected values worked out by hand.
      //       iv  data             ord fl   ir ov od              cnt
      add_vec(0, '0,               1,  0,   1, 0, '0,              1);
      add_vec(1, 164'h3C01_0004,   1,  0,   1, 1, 164'h3C01_0004,  2);
      add_vec(0, '0,               1,  0,   1, 0, '0,              2);
      add_vec(1, 164'h11,          0,  0,   1, 1, 164'h11,         3);
      add_vec(1, 164'h22,          0,  0,   0, 1, 164'h11,         3);
      add_vec(1, 164'h33,          0,  0,   0, 1, 164'h11,         3);
      add_vec(1, 164'h33,          1,  0,   1, 1, 164'h22,         3);
      add_vec(1, 164'h33,          1,  0,   1, 1, 164'h33,         3);
      add_vec(0, '0,               1,  0,   1, 0, '0,              3);
      add_vec(1, 164'h44,          0,  0,   1, 1, 164'h44,         4);
      add_vec(1, 164'h55,          0,  0,   0, 1, 164'h44,         4);
      add_vec(1, 164'h66,          0,  1,   1, 0, '0,              4);
      add_vec(1, 164'h77,          1,  1,   1, 0, '0,              5);
      add_vec(0, '0,               1,  0,   1, 0, '0,              6);
      add_vec(1, 164'h88,          1,  0,   1, 1, 164'h88,         7);
      add_vec(1, 164'h99,          1,  1,   1, 0, '0,              7);
      add_vec(0, '0,               1,  0,   1, 0, '0,              8);

      // Reset state
      Rst = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1; a_flush = 1'b0;
      idle_b();
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_a_in_ready",  a_in_ready,   0);
      chk("rst_a_out_valid", a_out_valid,  0);
      chk("rst_a_out_data",  a_out_data,   0);
      chk("rst_a_bubble",    a_bubble_cnt, 0);
      chk("rst_b_in_ready",  b_in_ready,   0);
      chk("rst_b_out_valid", b_out_valid,  0);
      chk("rst_b_bubble",    b_bubble_cnt, 0);

      // Release; pass-through ready rises before any edge
      @(negedge Clk);
      Rst = 1'b1;
      drive_a(vq[0]);
      #1;
      chk("b_ready_after_release", b_in_ready, 1);

      // Table-driven directed sequence on the skid instance
      for (int i = 0; i < vq.size(); i++) begin
         if (i > 0) begin
            @(negedge Clk);
            drive_a(vq[i]);
         end
         @(posedge Clk);
         #1;
         chk($sformatf("vec%0d_in_ready", i),  a_in_ready,   vq[i].e_ir);
         chk($sformatf("vec%0d_out_valid", i), a_out_valid,  vq[i].e_ov);
         chk($sformatf("vec%0d_out_data", i),  a_out_data,   vq[i].e_od);
         chk($sformatf("vec%0d_bubble", i),    a_bubble_cnt, vq[i].e_cnt);
      end

      // Instance B has been idle 17 edges; three more makes 20 -> saturated
      @(negedge Clk);
      a_in_valid = 1'b0; a_out_ready = 1'b1; a_flush = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("b_bubble_saturated", b_bubble_cnt, 4'hF);
      @(posedge Clk);
      #1;
      chk("b_bubble_held", b_bubble_cnt, 4'hF);

      // Pass-through mode: load, stall, release, drain, flush-with-input
      @(negedge Clk);
      b_in_valid = 1'b1; b_in_data = 20'h5A; b_out_ready = 1'b0;
      #1;
      chk("b_ready_empty", b_in_ready, 1);
      @(posedge Clk); #1;
      chk("b_load_valid", b_out_valid, 1);
      chk("b_load_data",  b_out_data,  20'h5A);
      @(negedge Clk);
      b_in_data = 20'hA5;
      #1;
      chk("b_ready_stalled", b_in_ready, 0);
      @(posedge Clk); #1;
      chk("b_stall_data", b_out_data, 20'h5A);
      @(negedge Clk);
      b_out_ready = 1'b1;
      #1;
      chk("b_ready_unstalled", b_in_ready, 1);
      @(posedge Clk); #1;
      chk("b_swap_data", b_out_data, 20'hA5);
      @(negedge Clk);
      b_in_valid = 1'b0;
      @(posedge Clk); #1;
      chk("b_drain_valid", b_out_valid, 0);
      chk("b_drain_data",  b_out_data,  0);
      @(negedge Clk);
      b_in_valid = 1'b1; b_in_data = 20'h77; b_flush = 1'b1;
      @(posedge Clk); #1;
      chk("b_flush_drop_valid", b_out_valid, 0);
      chk("b_flush_drop_data",  b_out_data,  0);
      @(negedge Clk);
      idle_b();

      // Streaming: 100 back-to-back transfers through the skid instance
      n_out = 0; k = 0; ir_drops = 0;
      for (int c = 0; c < 110; c++) begin
         @(negedge Clk);
         a_in_valid  = (k < 100);
         a_in_data   = DW_A'(k + 1);
         a_out_ready = 1'b1;
         #1;
         if (a_in_valid && !a_in_ready) ir_drops++;
         if (a_out_valid) begin
            chk("stream_data", a_out_data, DW_A'(n_out + 1));
            n_out++;
         end
         if (a_in_valid && a_in_ready) k++;
      end
      chk("stream_count", DW_A'(n_out), 100);
      chk("stream_ready_drops", DW_A'(ir_drops), 0);

      // Fill main and skid under stall, then assert reset between edges
      @(negedge Clk);
      a_in_valid = 1'b1; a_in_data = 164'hC1; a_out_ready = 1'b0;
      @(negedge Clk);
      a_in_data = 164'hC2;
      @(negedge Clk);
      a_in_valid = 1'b0;
      #1;
      chk("pre_rst_full_ready", a_in_ready, 0);
      #2;
      Rst = 1'b0;
      #1;
      chk("async_rst_out_valid", a_out_valid,  0);
      chk("async_rst_out_data",  a_out_data,   0);
      chk("async_rst_in_ready",  a_in_ready,   0);
      chk("async_rst_bubble",    a_bubble_cnt, 0);
      chk("async_rst_b_bubble",  b_bubble_cnt, 0);
      @(negedge Clk);
      Rst = 1'b1;
      a_out_ready = 1'b1;
      @(posedge Clk); #1;
      chk("post_rst_in_ready",  a_in_ready,  1);
      chk("post_rst_out_valid", a_out_valid, 0);

      // Random handshakes on both instances against a queue model
      for (int c = 0; c < 400; c++) begin
         @(negedge Clk);
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_in_data   = rand_a();
         a_out_ready = ($urandom_range(0, 9) < 6);
         a_flush     = ($urandom_range(0, 24) == 0);
         b_in_valid  = ($urandom_range(0, 3) != 0);
         b_in_data   = 20'($urandom);
         b_out_ready = ($urandom_range(0, 9) < 6);
         b_flush     = ($urandom_range(0, 24) == 0);
         #1;
         a_ix = a_in_valid & a_in_ready;
         a_ox = a_out_valid & a_out_ready;
         b_ix = b_in_valid & b_in_ready;
         b_ox = b_out_valid & b_out_ready;
         chk("rand_a_valid", a_out_valid, (qa.size() != 0));
         chk("rand_b_valid", b_out_valid, (qb.size() != 0));
         if (a_ox && qa.size() > 0) begin
            ea = qa.pop_front();
            chk("rand_a_data", a_out_data, ea);
         end
         if (b_ox && qb.size() > 0) begin
            eb = qb.pop_front();
            chk("rand_b_data", b_out_data, eb);
         end
         if (a_flush) qa.delete();
         else if (a_ix) qa.push_back(a_in_data);
         if (b_flush) qb.delete();
         else if (b_ix) qb.push_back(b_in_data);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
